// File: rtl/power_on_lock_pkg.sv
// Shared types and constants for the power-on lock bank.
package power_on_lock_pkg;

    localparam int FAIL_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        RESP    = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_KEY     = 2'd1,
        ERR_CH      = 2'd2,
        ERR_REFUSED = 2'd3
    } lock_err_t;

endpackage

// File: rtl/power_on_lock_fail_ctr.sv
// Saturating wrong-key counter. `reached` compares the value the counter
// will hold after this edge, so the caller can raise lockout on the same edge.
module power_on_lock_fail_ctr
    import power_on_lock_pkg::*;
#(
    parameter int MAX_FAIL = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inc,
    input  logic                  clr,
    output logic [FAIL_CNT_W-1:0] count,
    output logic                  reached
);

    localparam logic [FAIL_CNT_W-1:0] MAX_FAIL_C = FAIL_CNT_W'(MAX_FAIL);
    localparam logic [FAIL_CNT_W-1:0] CNT_MAX    = '1;

    logic [FAIL_CNT_W-1:0] count_sat_inc;
    logic [FAIL_CNT_W-1:0] count_d;

    always_comb begin
        count_sat_inc = (count == CNT_MAX) ? CNT_MAX : count + 1'b1;
        count_d       = count;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_sat_inc;
        end
        reached = (count_d >= MAX_FAIL_C);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/power_on_lock_bank.sv
// Bank of power-on lock bits, each released by a keyed request; repeated
// wrong keys push the bank into a lockout that only reset clears.
module power_on_lock_bank
    import power_on_lock_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                KEY_W      = 16,
    parameter logic [KEY_W-1:0]  UNLOCK_KEY = 16'hA5C3,
    parameter int                MAX_FAIL   = 3,
    parameter logic [NUM_CH-1:0] ONCE_MASK  = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    // Handshake: a request is taken on a rising edge where unlock_valid and
    // unlock_ready are both 1; ch/key are captured only then. Each accepted
    // request gets exactly one unlock_ack pulse two cycles later, with
    // unlock_ok/unlock_err meaningful only while unlock_ack is 1.
    input  logic                  unlock_valid,
    output logic                  unlock_ready,
    input  logic [3:0]            unlock_ch,
    input  logic [KEY_W-1:0]      unlock_key,
    input  logic [NUM_CH-1:0]     relock,
    output logic                  unlock_ack,
    output logic                  unlock_ok,
    output logic [1:0]            unlock_err,
    output logic [NUM_CH-1:0]     locked,
    output logic                  lockout,
    output logic [FAIL_CNT_W-1:0] fail_count,
    output lock_state_t           dbg_state
);

    localparam logic [4:0] NUM_CH_C = 5'(NUM_CH);

    lock_state_t       state;
    lock_state_t       state_d;
    logic [3:0]        ch_q;
    logic [KEY_W-1:0]  key_q;
    logic [NUM_CH-1:0] used;

    logic              accept;
    logic              eval_ok;
    lock_err_t         eval_err;
    logic [15:0]       used_pad;
    logic [15:0]       once_pad;
    logic [15:0]       ch_onehot;
    logic [NUM_CH-1:0] clear_mask;
    logic              resp_ok;
    logic              fail_inc;
    logic              fail_reached;
    logic              lockout_set;

    assign accept    = unlock_valid & unlock_ready;
    assign used_pad  = 16'(used);
    assign once_pad  = 16'(ONCE_MASK);
    assign ch_onehot = 16'd1 << ch_q;
    assign dbg_state = state;

    // unlock_ok/unlock_err are non-zero only in RESP, so they double as the
    // registered result that RESP commits.
    assign resp_ok     = (state == RESP) && unlock_ok;
    assign fail_inc    = (state == RESP) && (unlock_err == ERR_KEY);
    assign lockout_set = fail_inc && fail_reached;
    assign clear_mask  = resp_ok ? ch_onehot[NUM_CH-1:0] : '0;

    always_comb begin
        eval_ok  = 1'b0;
        eval_err = ERR_NONE;
        if (lockout) begin
            eval_err = ERR_REFUSED;
        end else if ({1'b0, ch_q} >= NUM_CH_C) begin
            eval_err = ERR_CH;
        end else if (once_pad[ch_q] && used_pad[ch_q]) begin
            eval_err = ERR_REFUSED;
        end else if (key_q != UNLOCK_KEY) begin
            eval_err = ERR_KEY;
        end else begin
            eval_ok = 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE, LOCKOUT: if (accept) state_d = CHECK;
            CHECK:         state_d = RESP;
            RESP:          state_d = (lockout || lockout_set) ? LOCKOUT : IDLE;
            default:       state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            unlock_ready <= 1'b1;
            ch_q         <= '0;
            key_q        <= '0;
            unlock_ack   <= 1'b0;
            unlock_ok    <= 1'b0;
            unlock_err   <= ERR_NONE;
            locked       <= '1;
            used         <= '0;
            lockout      <= 1'b0;
        end else begin
            state        <= state_d;
            unlock_ready <= (state_d == IDLE) || (state_d == LOCKOUT);
            if (accept) begin
                ch_q  <= unlock_ch;
                key_q <= unlock_key;
            end
            unlock_ack <= (state == CHECK);
            unlock_ok  <= (state == CHECK) && eval_ok;
            unlock_err <= (state == CHECK) ? eval_err : ERR_NONE;
            // Relock is ORed last so it beats a same-cycle unlock.
            locked     <= (locked & ~clear_mask) | relock;
            used       <= used | clear_mask;
            lockout    <= lockout | lockout_set;
        end
    end

    power_on_lock_fail_ctr #(
        .MAX_FAIL (MAX_FAIL)
    ) u_fail_ctr (
        .clk     (clk),
        .resetn  (resetn),
        .inc     (fail_inc),
        .clr     (resp_ok),
        .count   (fail_count),
        .reached (fail_reached)
    );

endmodule

// File: doc/power_on_lock_bank.md
# power_on_lock_bank

Multi-channel successor to the single power-on lock register. It holds NUM_CH lock bits that are all set on power-on/reset. Each channel is unlocked only through a keyed request handshake. Wrong keys are counted, and after MAX_FAIL of them the bank enters a lockout state that persists until reset. The block sits between the debug/config bus bridge and the protected register groups, which gate writes on their `locked` bit.

## Interface
Parameters:
- NUM_CH, 4, number of lock channels (1..16)
- KEY_W, 16, unlock key width
- UNLOCK_KEY, 16'hA5C3, key value that unlocks any channel
- MAX_FAIL, 3, wrong-key attempts that trigger lockout (1..15)
- ONCE_MASK, 0, bit i = 1: channel i may be unlocked at most once per reset

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- unlock_valid  in  1  unlock request valid
- unlock_ready  out  1  block can accept a request
- unlock_ch  in  4  target channel index
- unlock_key  in  KEY_W  presented key
- relock  in  NUM_CH  per-channel relock strobe
- unlock_ack  out  1  one-cycle response pulse
- unlock_ok  out  1  qualified by unlock_ack; 1 = channel unlocked
- unlock_err  out  2  qualified by unlock_ack; 0 none, 1 bad key, 2 bad channel, 3 refused (once-used or lockout)
- locked  out  NUM_CH  lock state per channel
- lockout  out  1  sticky lockout flag
- fail_count  out  4  wrong-key count

## Operation
- Reset values: locked = all 1, lockout = 0, fail_count = 0, unlock_ack = 0, unlock_ok = 0, unlock_err = 0, unlock_ready = 1, once-used flags = 0, FSM in IDLE.
- FSM states:
  - IDLE: ready = 1. On valid & ready, capture ch/key and go to CHECK.
  - CHECK: ready = 0. Evaluate the request and go to RESP.
  - RESP: ack = 1 for one cycle, update state, then go to IDLE, or to LOCKOUT if the fail threshold was reached.
  - LOCKOUT: ready = 1. Each request is acked as err 3 through CHECK/RESP and returns to LOCKOUT. Exit only on reset.
- Evaluation priority:
  1. lockout → err 3
  2. ch ≥ NUM_CH → err 2
  3. ONCE_MASK[ch] & used[ch] → err 3
  4. key ≠ UNLOCK_KEY → err 1
  5. otherwise ok
- On ok in RESP: locked[ch] ← 0, used[ch] ← 1, fail_count ← 0.
- On err 1: fail_count increments, saturating at 15. If the new value ≥ MAX_FAIL, lockout ← 1.
- err 2 and err 3 do not change fail_count.
- Unlocking an already-unlocked channel returns ok, consumes once-use, and clears fail_count.
- relock[i] = 1 sets locked[i] ← 1 in the next cycle, in any state including LOCKOUT.
- Relock in the same cycle as an ok unlock of the same channel: relock wins, and locked stays 1. unlock_ok is still 1.
- Lockout does not change the locked bits; it only blocks future unlocks.
- resetn low at any time: all registers return to reset values asynchronously, and an in-flight request is dropped with no ack.
- unlock_ch, unlock_key and unlock_valid are sampled only on the accept edge. Changes afterwards are ignored.

## Timing
- Request accepted at edge N; CHECK during cycle N+1; unlock_ack/ok/err high during cycle N+2.
- locked, fail_count and lockout reflect the result from cycle N+3.
- unlock_ready is high in the cycle after the ack, so the back-to-back throughput is one request per 3 cycles.
- relock latency is 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- power_on_lock_pkg:
  - FSM state enum: IDLE, CHECK, RESP, LOCKOUT.
  - unlock_err code enum: ERR_NONE, ERR_KEY, ERR_CH, ERR_REFUSED.
  - FAIL_CNT_W = 4 constant.
- Sub-module power_on_lock_fail_ctr: saturating 4-bit counter with inc, clr and threshold compare. It outputs count and reached.
- Top level: FSM, request capture registers, locked/used register vectors.

## Test plan
- Reset, then idle 5 cycles → locked = 4'hF, lockout = 0, ready = 1, no ack.
- Request ch 2 with key 16'hA5C3 → ack in cycle N+2 with ok = 1, err = 0; locked = 4'hB from N+3; fail_count = 0.
- Three requests to ch 1 with key 16'h0000 → err = 1 each; fail_count goes 1, 2, 3; lockout = 1 after the third. A following correct-key request gets err = 3 and locked stays unchanged.
- Request ch 5 (NUM_CH = 4) → err = 2, fail_count unchanged. With ONCE_MASK = 4'b0001: unlock ch 0 ok, relock[0], unlock again → err = 3, locked[0] = 1.
- Correct unlock of ch 3 with relock[3] pulsed in cycle N+2 → ok = 1, and locked[3] is still 1 at N+3.
- Assert resetn low in CHECK → no ack; after release locked = 4'hF, fail_count = 0, and ready = 1 on the first cycle.
